// File: rtl/mdr_load_unit.sv
// Memory data register: issues a load wait, captures mem_data on mem_valid and extracts/extends the addressed field.
// Result lands on the falling edge that samples mem_valid; no backpressure, the unit waits in WAIT until valid, flush or timeout.
module mdr_load_unit #(
  parameter int BUS_WIDTH      = 32,
  parameter int OFF_W          = 2,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TMR_W          = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           funct3,
  input  logic [OFF_W-1:0]     addr_lo,
  input  logic                 flush,
  input  logic [BUS_WIDTH-1:0] mem_data,
  input  logic                 mem_valid,
  output logic [BUS_WIDTH-1:0] data_out,
  output logic [BUS_WIDTH-1:0] raw_out,
  output logic                 busy,
  output logic                 data_valid,
  output logic                 done,
  output logic                 err_align,
  output logic                 err_timeout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [TMR_W-1:0] TMO_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : TMR_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]           state;
  logic [2:0]           f3_q;
  logic [OFF_W-1:0]     off_q;
  logic [TMR_W-1:0]     cnt;
  logic                 illegal;
  logic [BUS_WIDTH-1:0] shifted;
  logic [BUS_WIDTH-1:0] ext;
  logic [7:0]           fld_b;
  logic [15:0]          fld_h;
  logic [31:0]          fld_w;

  assign busy       = (state == S_WAIT);
  assign data_valid = (state == S_HOLD);

  // Alignment is judged on the live request, before anything is latched.
  always_comb begin
    illegal = 1'b0;
    case (funct3)
      3'b000, 3'b100: illegal = 1'b0;
      3'b001, 3'b101: illegal = addr_lo[0];
      3'b010:         illegal = (addr_lo[1:0] != 2'b00);
      3'b110:         illegal = (BUS_WIDTH == 32) || (addr_lo[1:0] != 2'b00);
      3'b011:         illegal = (BUS_WIDTH == 32) || (addr_lo != '0);
      default:        illegal = 1'b1;
    endcase
  end

  assign shifted = mem_data >> {off_q, 3'b000};
  assign fld_b   = shifted[7:0];
  assign fld_h   = shifted[15:0];
  assign fld_w   = shifted[31:0];

  always_comb begin
    ext = shifted;
    case (f3_q)
      3'b000:  ext = BUS_WIDTH'($signed(fld_b));
      3'b001:  ext = BUS_WIDTH'($signed(fld_h));
      3'b010:  ext = BUS_WIDTH'($signed(fld_w));
      3'b100:  ext = BUS_WIDTH'(fld_b);
      3'b101:  ext = BUS_WIDTH'(fld_h);
      3'b110:  ext = BUS_WIDTH'(fld_w);
      default: ext = shifted;
    endcase
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      f3_q        <= '0;
      off_q       <= '0;
      cnt         <= '0;
      data_out    <= '0;
      raw_out     <= '0;
      done        <= 1'b0;
      err_align   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_HOLD: begin
          if (start) begin
            f3_q        <= funct3;
            off_q       <= addr_lo;
            cnt         <= '0;
            err_timeout <= 1'b0;
            err_align   <= illegal;
            state       <= illegal ? S_IDLE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush) begin
            state <= S_IDLE;
          end else if (mem_valid) begin
            raw_out  <= mem_data;
            data_out <= ext;
            done     <= 1'b1;
            state    <= S_HOLD;
          end else if ((TIMEOUT_CYCLES != 0) && (cnt == TMO_LAST)) begin
            err_timeout <= 1'b1;
            state       <= S_IDLE;
          end else begin
            cnt <= cnt + TMR_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mdr_load_unit.md
Name: mdr_load_unit

Overview:
- Parametrised successor to the memory data register in the multi-cycle RISC-V datapath.
- Issues a load wait to data memory and captures the returned word under a valid handshake.
- Extracts and sign/zero-extends the addressed byte, halfword, word or doubleword per the load funct3 and address offset.
- Flags misaligned or illegal loads and memory timeouts. Holds the result for the write-back cycle.

Parameters:
- BUS_WIDTH, 32, datapath width; legal values 32 or 64.
- OFF_W, 2, address offset width; must equal log2(BUS_WIDTH/8), i.e. 2 or 3.
- TIMEOUT_CYCLES, 16, WAIT cycles before timeout; 0 disables the timeout.
- TMR_W, 8, timeout counter width; must satisfy 2^TMR_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock; all state updates on the falling edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  control FSM requests a load; sampled in IDLE/HOLD only.
- funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
- addr_lo  input  OFF_W  low address bits (byte offset in bus word).
- flush  input  1  abort the outstanding load.
- mem_data  input  BUS_WIDTH  raw word from data memory.
- mem_valid  input  1  mem_data valid this cycle.
- data_out  output  BUS_WIDTH  extracted, extended load result.
- raw_out  output  BUS_WIDTH  last captured raw word.
- busy  output  1  high in WAIT.
- data_valid  output  1  high in HOLD.
- done  output  1  one-cycle pulse on capture.
- err_align  output  1  sticky misaligned/illegal flag.
- err_timeout  output  1  sticky timeout flag.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-low.
  - rst=0 immediately forces state IDLE.
  - Outputs under reset: data_out=0, raw_out=0, busy=0, data_valid=0, done=0, err_align=0, err_timeout=0. Counter=0, latched funct3/offset=0.
  - Reset mid-WAIT discards the load.
- States: IDLE, WAIT, HOLD. Encoding is free.
- IDLE/HOLD with start=1:
  - Latch funct3 and addr_lo. Clear both error flags and the counter. done=0.
  - Illegal load → err_align=1, go IDLE, data_out/raw_out unchanged. Illegal means:
    - funct3 011 or 110 when BUS_WIDTH=32;
    - funct3 111;
    - halfword with addr_lo[0]=1;
    - word with addr_lo[1:0]≠0;
    - LD with addr_lo≠0.
  - Otherwise go WAIT.
  - mem_valid is ignored outside WAIT.
- IDLE/HOLD with start=0: hold state and all outputs. done falls after one cycle.
- WAIT, priority order:
  - flush=1 → IDLE, no capture, no flag change.
  - mem_valid=1 → raw_out<=mem_data; data_out<=extracted value; done=1 for exactly one cycle; go HOLD.
  - TIMEOUT_CYCLES≠0 and counter==TIMEOUT_CYCLES-1 → err_timeout=1, go IDLE, data unchanged.
  - Otherwise counter++.
- Timeout timing: WAIT lasts at most TIMEOUT_CYCLES falling edges. With TIMEOUT_CYCLES=0 the unit waits indefinitely.
- mem_valid and timeout on the same edge: capture wins, no timeout.
- Extraction uses the latched offset and funct3:
  - byte = mem_data[8*off+7 : 8*off]; halfword at 8*off; word at 8*off (off 0 or 4 on 64-bit).
  - Signed types replicate the MSB up to BUS_WIDTH; unsigned types zero-fill.
  - LW on 64-bit sign-extends; LWU zero-extends.
- HOLD: data_out/raw_out stable until the next capture or reset. Back-to-back start from HOLD is legal with no idle cycle.
- Latency: start edge → WAIT; result visible on the falling edge where mem_valid=1 is sampled. Single-cycle memory gives 2 edges start-to-done.

Test Plan:
- Reset: assert rst=0 mid-WAIT → all outputs 0 and state IDLE asynchronously; after release, start+LW off 0 with mem_data=0xDEADBEEF → data_out=0xDEADBEEF, done one cycle, data_valid=1.
- LB off 3, mem_data=0x80FF_1234 → data_out=0xFFFFFF80. LBU same → 0x00000080. LHU off 2 → 0x000080FF. LH off 0 → 0x00001234.
- Alignment: LH off 1 → err_align=1, no WAIT, data_out unchanged. LW off 2 → err_align=1. funct3=011 at BUS_WIDTH=32 → err_align=1. Next legal start clears the flag.
- Timeout: TIMEOUT_CYCLES=4, mem_valid held 0 → err_timeout=1 on the 4th WAIT edge, busy falls. Repeat with mem_valid=1 on the 4th edge → capture, no timeout.
- Flush, then back-to-back: flush in WAIT with mem_valid=1 → IDLE, raw_out unchanged. Start from HOLD with LW then immediate LHU → two done pulses, second data_out zero-extended.
- BUS_WIDTH=64, OFF_W=3: LD off 0, mem_data=0x8000_0000_0000_0001 → same value. LW off 4 → 0xFFFFFFFF80000000. LWU off 4 → 0x0000000080000000.
